// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - multi-issue instruction fetch: PC, redirect flush and bundle FIFO to decode
module fetch_unit #(
  parameter int ADDR_W    = 8,
  parameter int INSTR_W   = 32,
  parameter int ISSUE_W   = 2,
  parameter int BUF_DEPTH = 4,
  parameter int RESET_PC  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [ISSUE_W*INSTR_W-1:0]   imem_instr,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [ISSUE_W*INSTR_W-1:0]   id_instr,
  output logic [ADDR_W-1:0]            id_pc,
  output logic [$clog2(BUF_DEPTH):0]   fifo_count
);

  localparam int PTR_W    = $clog2(BUF_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int BUNDLE_W = ISSUE_W * INSTR_W;

  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_buf    [BUF_DEPTH];
  logic [BUNDLE_W-1:0] instr_buf [BUF_DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                pop;
  logic                push;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a
  // new bundle while decode drains it; a redirect suppresses any push.
  assign full = (count == CNT_W'(BUF_DEPTH));
  assign pop  = id_valid & id_ready;
  assign push = ~redirect_valid & (~full | pop);

  assign imem_addr  = pc_q;
  assign id_valid   = (count != '0);
  assign id_instr   = instr_buf[rd_ptr];
  assign id_pc      = pc_buf[rd_ptr];
  assign fifo_count = count;

  // Bundle storage; entries are only read while counted, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      pc_buf[wr_ptr]    <= pc_q;
      instr_buf[wr_ptr] <= imem_instr;
    end
  end

  // PC, pointers and occupancy; a redirect flushes the queue and drops any pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= ADDR_W'(RESET_PC);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc_q   <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q   <= pc_q + ADDR_W'(ISSUE_W);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule
